// File: rtl/attn_pkg.sv
// Shared types and helpers for the self-attention projection sequencing logic.
package attn_pkg;

    localparam int unsigned NUM_PASSES = 3;
    localparam int unsigned PASS_ID_W  = 2;

    // Pass selector; PASS_NONE parks every bank port in its inactive state.
    typedef enum logic [PASS_ID_W-1:0] {
        PASS_Q    = 2'd0,
        PASS_K    = 2'd1,
        PASS_V    = 2'd2,
        PASS_NONE = 2'd3
    } pass_t;

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } sched_state_t;

    // Lowest enabled pass in a mask, Q first; PASS_NONE when the mask is empty.
    function automatic pass_t lowest_pass(input logic [NUM_PASSES-1:0] m);
        pass_t p;
        if (m[0])      p = PASS_Q;
        else if (m[1]) p = PASS_K;
        else if (m[2]) p = PASS_V;
        else           p = PASS_NONE;
        return p;
    endfunction

endpackage

// File: rtl/bank_port_mux.sv
// Steers one engine memory port onto the bank selected by the active pass.
// Control strobes are active-low; unselected banks (and sel = none) see all ones.
module bank_port_mux
    import attn_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CTL_W  = 1
) (
    input  logic [PASS_ID_W-1:0]                 sel,
    input  logic [CTL_W-1:0]                     eng_ctl,
    input  logic [ADDR_W-1:0]                    eng_addr,
    output logic [DATA_W-1:0]                    eng_rdata,
    output logic [NUM_PASSES-1:0][CTL_W-1:0]     bank_ctl,
    output logic [ADDR_W-1:0]                    bank_addr,
    input  logic [NUM_PASSES*DATA_W-1:0]         bank_rdata
);

    // Per-bank strobe gating and read-data select; address is broadcast.
    always_comb begin
        bank_addr = eng_addr;
        bank_ctl  = '1;
        eng_rdata = '0;
        for (int k = 0; k < int'(NUM_PASSES); k++) begin
            if (sel == PASS_ID_W'(k)) begin
                bank_ctl[k] = eng_ctl;
                eng_rdata   = bank_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/qkv_pass_scheduler.sv
// Time-shares one QKV projection engine across the Q, K and V passes:
// clears and launches the engine per enabled pass, steers its memory ports
// to the active pass's banks, and reports completion, cycle counts and timeouts.
module qkv_pass_scheduler
    import attn_pkg::*;
#(
    parameter logic [19:0]  TIMEOUT_CYCLES = 20'd1000000,
    parameter int unsigned  CNT_W          = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_PASSES-1:0]         pass_mask,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [PASS_ID_W-1:0]          pass_id,
    output logic [CNT_W-1:0]              pass_cycles,
    output logic                          eng_clr,
    output logic                          eng_en,
    input  logic                          eng_finished,
    input  logic                          eng_w_ceb,
    input  logic [9:0]                    eng_w_addr,
    output logic [127:0]                  eng_w_dout,
    output logic [NUM_PASSES-1:0]         w_ceb,
    output logic [9:0]                    w_addr,
    input  logic [NUM_PASSES*128-1:0]     w_dout,
    input  logic                          eng_o_ceb,
    input  logic                          eng_o_wen,
    input  logic [6:0]                    eng_o_addr,
    input  logic [127:0]                  eng_o_din,
    output logic [NUM_PASSES-1:0]         o_ceb,
    output logic [NUM_PASSES-1:0]         o_wen,
    output logic [6:0]                    o_addr,
    output logic [127:0]                  o_din
);

    localparam int unsigned     DATA_W       = 128;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 20'd1);

    sched_state_t            state_q, state_d;
    logic [NUM_PASSES-1:0]   mask_q, mask_d;
    pass_t                   pass_id_q, pass_id_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        pass_cycles_q, pass_cycles_d;

    logic                    abort_hit;
    logic                    wait_timeout;

    logic [NUM_PASSES-1:0][0:0] w_bank_ctl;
    logic [NUM_PASSES-1:0][1:0] o_bank_ctl;
    logic [DATA_W-1:0]          unused_o_rdata;

    // Abort only matters while a sequence is in flight; finished beats timeout.
    assign abort_hit    = abort && (state_q != ST_IDLE);
    assign wait_timeout = (state_q == ST_WAIT) && !eng_finished && (cnt_q == TIMEOUT_LAST);

    // Scheduler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            pass_id_q     <= PASS_NONE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            pass_cycles_q <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            pass_id_q     <= pass_id_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            pass_cycles_q <= pass_cycles_d;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        pass_id_d     = pass_id_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        pass_cycles_d = pass_cycles_q;

        if (abort_hit) begin
            state_d   = ST_IDLE;
            mask_d    = '0;
            pass_id_d = PASS_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_d = pass_mask;
                        err_d  = 1'b0;
                        if (pass_mask == '0) begin
                            pass_id_d = PASS_NONE;
                            state_d   = ST_FINISH;
                        end else begin
                            pass_id_d = lowest_pass(pass_mask);
                            state_d   = ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_d = ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (eng_finished) begin
                        pass_cycles_d = cnt_q + CNT_W'(1);
                        mask_d        = mask_q & ~(NUM_PASSES'(1) << pass_id_q);
                        state_d       = ST_NEXT;
                    end else if (wait_timeout) begin
                        err_d     = 1'b1;
                        mask_d    = '0;
                        pass_id_d = PASS_NONE;
                        state_d   = ST_FINISH;
                    end
                end
                ST_NEXT: begin
                    if (mask_q != '0) begin
                        pass_id_d = lowest_pass(mask_q);
                        state_d   = ST_CLEAR;
                    end else begin
                        pass_id_d = PASS_NONE;
                        state_d   = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    mask_d    = '0;
                    pass_id_d = PASS_NONE;
                end
            endcase
        end
    end

    // Engine handshake and status decode; abort suppresses launch and done.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_FINISH) && !abort;
        eng_en  = (state_q == ST_LAUNCH) && !abort;
        eng_clr = (state_q == ST_CLEAR) || abort_hit || wait_timeout;
    end

    assign err         = err_q;
    assign pass_id     = pass_id_q;
    assign pass_cycles = pass_cycles_q;
    assign o_din       = eng_o_din;

    // Weight-read port steering.
    bank_port_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (10),
        .CTL_W  (1)
    ) u_w_mux (
        .sel        (pass_id_q),
        .eng_ctl    (eng_w_ceb),
        .eng_addr   (eng_w_addr),
        .eng_rdata  (eng_w_dout),
        .bank_ctl   (w_bank_ctl),
        .bank_addr  (w_addr),
        .bank_rdata (w_dout)
    );

    // Output-write port steering; ctl bit 0 is ceb, bit 1 is wen.
    bank_port_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (7),
        .CTL_W  (2)
    ) u_o_mux (
        .sel        (pass_id_q),
        .eng_ctl    ({eng_o_wen, eng_o_ceb}),
        .eng_addr   (eng_o_addr),
        .eng_rdata  (unused_o_rdata),
        .bank_ctl   (o_bank_ctl),
        .bank_addr  (o_addr),
        .bank_rdata ('0)
    );

    // Flatten the per-bank strobes onto the bank-ordered ports.
    always_comb begin
        for (int k = 0; k < int'(NUM_PASSES); k++) begin
            w_ceb[k] = w_bank_ctl[k][0];
            o_ceb[k] = o_bank_ctl[k][0];
            o_wen[k] = o_bank_ctl[k][1];
        end
    end

endmodule

// File: tb/tb_qkv_pass_scheduler.sv
// Directed bench for qkv_pass_scheduler: multi-pass sequencing, masks,
// port steering, abort, ignored inputs, watchdog timeout and async reset.
module tb_qkv_pass_scheduler;

    localparam logic [127:0] PAT_Q = {4{32'h1111_AAAA}};
    localparam logic [127:0] PAT_K = {4{32'h2222_BBBB}};
    localparam logic [127:0] PAT_V = {4{32'h3333_CCCC}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start, abort, eng_finished;
    logic [2:0]   pass_mask;
    logic         eng_w_ceb, eng_o_ceb, eng_o_wen;
    logic [9:0]   eng_w_addr;
    logic [6:0]   eng_o_addr;
    logic [127:0] eng_o_din;
    logic [383:0] w_dout;

    logic         busy, done, err, eng_clr, eng_en;
    logic [1:0]   pass_id;
    logic [19:0]  pass_cycles;
    logic [127:0] eng_w_dout, o_din;
    logic [2:0]   w_ceb, o_ceb, o_wen;
    logic [9:0]   w_addr;
    logic [6:0]   o_addr;

    logic         t_start, t_abort, t_fin;
    logic [2:0]   t_mask;
    logic         t_busy, t_done, t_err, t_eng_clr, t_eng_en;
    logic [1:0]   t_pass_id;
    logic [19:0]  t_pass_cycles;
    logic [127:0] t_eng_w_dout, t_o_din;
    logic [2:0]   t_w_ceb, t_o_ceb, t_o_wen;
    logic [9:0]   t_w_addr;
    logic [6:0]   t_o_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qkv_pass_scheduler #(.TIMEOUT_CYCLES(20'd1000000), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .pass_mask(pass_mask), .abort(abort),
        .busy(busy), .done(done), .err(err), .pass_id(pass_id), .pass_cycles(pass_cycles),
        .eng_clr(eng_clr), .eng_en(eng_en), .eng_finished(eng_finished),
        .eng_w_ceb(eng_w_ceb), .eng_w_addr(eng_w_addr), .eng_w_dout(eng_w_dout),
        .w_ceb(w_ceb), .w_addr(w_addr), .w_dout(w_dout),
        .eng_o_ceb(eng_o_ceb), .eng_o_wen(eng_o_wen), .eng_o_addr(eng_o_addr), .eng_o_din(eng_o_din),
        .o_ceb(o_ceb), .o_wen(o_wen), .o_addr(o_addr), .o_din(o_din)
    );

    qkv_pass_scheduler #(.TIMEOUT_CYCLES(20'd16), .CNT_W(20)) dut_to (
        .clk(clk), .rst(rst), .start(t_start), .pass_mask(t_mask), .abort(t_abort),
        .busy(t_busy), .done(t_done), .err(t_err), .pass_id(t_pass_id), .pass_cycles(t_pass_cycles),
        .eng_clr(t_eng_clr), .eng_en(t_eng_en), .eng_finished(t_fin),
        .eng_w_ceb(eng_w_ceb), .eng_w_addr(eng_w_addr), .eng_w_dout(t_eng_w_dout),
        .w_ceb(t_w_ceb), .w_addr(t_w_addr), .w_dout(w_dout),
        .eng_o_ceb(eng_o_ceb), .eng_o_wen(eng_o_wen), .eng_o_addr(eng_o_addr), .eng_o_din(eng_o_din),
        .o_ceb(t_o_ceb), .o_wen(t_o_wen), .o_addr(t_o_addr), .o_din(t_o_din)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_dout(input logic [1:0] id);
        logic [127:0] r;
        case (id)
            2'd0:    r = PAT_Q;
            2'd1:    r = PAT_K;
            2'd2:    r = PAT_V;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] exp_ceb(input logic [1:0] id);
        logic [2:0] r;
        case (id)
            2'd0:    r = 3'b110;
            2'd1:    r = 3'b101;
            2'd2:    r = 3'b011;
            default: r = 3'b111;
        endcase
        return r;
    endfunction

    // Entered in the CLEAR cycle of a pass; engine finishes 50 cycles after eng_en.
    // Returns in the next pass's CLEAR cycle, or in IDLE after the last pass.
    task automatic do_pass(input logic [1:0] id, input logic last, input logic poke);
        chk("clear_clr", 128'(eng_clr), 128'(1));
        chk("clear_en", 128'(eng_en), 128'(0));
        chk("clear_pid", 128'(pass_id), 128'(id));
        chk("w_ceb", 128'(w_ceb), 128'(exp_ceb(id)));
        chk("o_ceb", 128'(o_ceb), 128'(exp_ceb(id)));
        chk("o_wen", 128'(o_wen), 128'(exp_ceb(id)));
        chk("w_dout_sel", eng_w_dout, exp_dout(id));
        if (poke) begin
            start     = 1'b1;
            pass_mask = 3'b111;
        end
        tick();
        start = 1'b0;
        chk("launch_en", 128'(eng_en), 128'(1));
        chk("launch_clr", 128'(eng_clr), 128'(0));
        if (poke) eng_finished = 1'b1;
        tick();
        eng_finished = 1'b0;
        repeat (49) tick();
        chk("wait_pid", 128'(pass_id), 128'(id));
        chk("wait_w_ceb", 128'(w_ceb), 128'(exp_ceb(id)));
        chk("wait_dout", eng_w_dout, exp_dout(id));
        chk("wait_busy", 128'(busy), 128'(1));
        eng_finished = 1'b1;
        tick();
        eng_finished = 1'b0;
        chk("pass_cycles", 128'(pass_cycles), 128'(50));
        chk("next_en", 128'(eng_en), 128'(0));
        chk("next_done", 128'(done), 128'(0));
        tick();
        if (last) begin
            chk("fin_done", 128'(done), 128'(1));
            chk("fin_pid", 128'(pass_id), 128'(3));
            chk("fin_clr", 128'(eng_clr), 128'(0));
            tick();
            chk("idle_busy", 128'(busy), 128'(0));
            chk("idle_done", 128'(done), 128'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; eng_finished = 1'b0; pass_mask = 3'b000;
        t_start = 1'b0; t_abort = 1'b0; t_fin = 1'b0; t_mask = 3'b000;
        eng_w_ceb = 1'b0; eng_o_ceb = 1'b0; eng_o_wen = 1'b0;
        eng_w_addr = 10'h2A5; eng_o_addr = 7'h5A; eng_o_din = {4{32'hDEAD_BEEF}};
        w_dout = {PAT_V, PAT_K, PAT_Q};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_clr", 128'(eng_clr), 128'(0));
        chk("rst_en", 128'(eng_en), 128'(0));
        chk("rst_pid", 128'(pass_id), 128'(3));
        chk("rst_pcyc", 128'(pass_cycles), 128'(0));
        chk("rst_w_ceb", 128'(w_ceb), 128'(7));
        chk("rst_o_ceb", 128'(o_ceb), 128'(7));
        chk("rst_o_wen", 128'(o_wen), 128'(7));
        chk("rst_dout", eng_w_dout, 128'(0));
        chk("w_addr", 128'(w_addr), 128'(10'h2A5));
        chk("o_addr", 128'(o_addr), 128'(7'h5A));
        chk("o_din", o_din, {4{32'hDEAD_BEEF}});
        rst = 1'b0;
        tick();

        // All three passes
        start = 1'b1; pass_mask = 3'b111;
        tick();
        start = 1'b0;
        chk("s111_busy", 128'(busy), 128'(1));
        chk("s111_err", 128'(err), 128'(0));
        do_pass(2'd0, 1'b0, 1'b0);
        do_pass(2'd1, 1'b0, 1'b0);
        do_pass(2'd2, 1'b1, 1'b0);

        // Q and V only; K bank stays deselected via exp_ceb checks
        start = 1'b1; pass_mask = 3'b101;
        tick();
        start = 1'b0;
        do_pass(2'd0, 1'b0, 1'b0);
        do_pass(2'd2, 1'b1, 1'b0);

        // Empty mask
        start = 1'b1; pass_mask = 3'b000;
        tick();
        start = 1'b0;
        chk("m0_done", 128'(done), 128'(1));
        chk("m0_busy", 128'(busy), 128'(1));
        chk("m0_en", 128'(eng_en), 128'(0));
        chk("m0_clr", 128'(eng_clr), 128'(0));
        chk("m0_pid", 128'(pass_id), 128'(3));
        tick();
        chk("m0_busy_end", 128'(busy), 128'(0));
        chk("m0_done_end", 128'(done), 128'(0));

        // eng_finished in IDLE is ignored
        eng_finished = 1'b1;
        tick();
        eng_finished = 1'b0;
        tick();
        chk("idle_fin_busy", 128'(busy), 128'(0));
        chk("idle_fin_pcyc", 128'(pass_cycles), 128'(50));

        // Abort during K WAIT together with eng_finished
        start = 1'b1; pass_mask = 3'b011;
        tick();
        start = 1'b0;
        do_pass(2'd0, 1'b0, 1'b0);
        chk("ab_pid", 128'(pass_id), 128'(1));
        tick();
        repeat (10) tick();
        abort = 1'b1; eng_finished = 1'b1;
        #1;
        chk("ab_clr", 128'(eng_clr), 128'(1));
        chk("ab_done", 128'(done), 128'(0));
        tick();
        abort = 1'b0; eng_finished = 1'b0;
        #1;
        chk("ab_busy", 128'(busy), 128'(0));
        chk("ab_clr_end", 128'(eng_clr), 128'(0));
        chk("ab_done_end", 128'(done), 128'(0));
        chk("ab_pid_end", 128'(pass_id), 128'(3));
        chk("ab_pcyc", 128'(pass_cycles), 128'(50));
        chk("ab_w_ceb", 128'(w_ceb), 128'(7));
        tick();
        chk("ab_done_late", 128'(done), 128'(0));

        // K only, with start re-pulsed and eng_finished injected in LAUNCH
        start = 1'b1; pass_mask = 3'b010;
        tick();
        start = 1'b0;
        do_pass(2'd1, 1'b1, 1'b1);
        chk("k_only_pcyc", 128'(pass_cycles), 128'(50));

        // Watchdog on the short-timeout instance
        t_start = 1'b1; t_mask = 3'b001;
        tick();
        t_start = 1'b0;
        chk("to_clear", 128'(t_eng_clr), 128'(1));
        tick();
        chk("to_en", 128'(t_eng_en), 128'(1));
        repeat (15) tick();
        chk("to_pre_clr", 128'(t_eng_clr), 128'(0));
        chk("to_pre_err", 128'(t_err), 128'(0));
        tick();
        chk("to_clr", 128'(t_eng_clr), 128'(1));
        chk("to_pre_done", 128'(t_done), 128'(0));
        tick();
        chk("to_done", 128'(t_done), 128'(1));
        chk("to_err", 128'(t_err), 128'(1));
        chk("to_pid", 128'(t_pass_id), 128'(3));
        tick();
        chk("to_idle", 128'(t_busy), 128'(0));
        chk("to_err_sticky", 128'(t_err), 128'(1));
        chk("to_w_ceb", 128'(t_w_ceb), 128'(7));
        chk("to_o_ceb", 128'(t_o_ceb), 128'(7));
        chk("to_o_wen", 128'(t_o_wen), 128'(7));
        chk("to_dout", t_eng_w_dout, 128'(0));
        chk("to_w_addr", 128'(t_w_addr), 128'(10'h2A5));
        chk("to_o_addr", 128'(t_o_addr), 128'(7'h5A));
        chk("to_o_din", t_o_din, {4{32'hDEAD_BEEF}});
        chk("to_pcyc", 128'(t_pass_cycles), 128'(0));
        t_start = 1'b1; t_mask = 3'b000;
        tick();
        t_start = 1'b0;
        chk("to_err_clr", 128'(t_err), 128'(0));
        chk("to_done2", 128'(t_done), 128'(1));
        chk("to_en2", 128'(t_eng_en), 128'(0));
        tick();

        // Asynchronous reset mid-pass
        start = 1'b1; pass_mask = 3'b111;
        tick();
        start = 1'b0;
        tick();
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_pid", 128'(pass_id), 128'(3));
        chk("arst_pcyc", 128'(pass_cycles), 128'(0));
        chk("arst_w_ceb", 128'(w_ceb), 128'(7));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_idle", 128'(busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
